// File: rtl/iq_fs4_upconv.sv
`default_nettype none
// ============================================================================
// Module   : iq_fs4_upconv
// Purpose  : fs/4 IQ-to-real upconverter (Q, I, -Q, -I rotation per accepted
//            sample) with saturating negation and a sticky clip counter.
// Revision : 1.0 - initial release
// ============================================================================
module iq_fs4_upconv #(
  parameter int W     = 12,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic signed [W-1:0] idi,
  input  logic signed [W-1:0] idq,
  output logic signed [W-1:0] od,
  output logic                od_valid,
  output logic                sat_flag,
  output logic [CNT_W-1:0]    sat_cnt
);

  localparam logic signed [W-1:0] C_MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [CNT_W-1:0]    C_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]          phase_q, phase_d;
  logic [1:0]          ph_use;
  logic                v1_q;
  logic signed [W-1:0] i1_q, q1_q;
  logic [1:0]          p1_q;
  logic signed [W-1:0] od_q, od_d;
  logic                vld_q, sat_q, sat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [W:0]   neg_src, neg_full;
  logic                clip;
  logic signed [W-1:0] neg_val;

  // sync forces phase 0 for the sample it arrives with; ignored without en
  always_comb begin
    ph_use  = sync ? 2'd0 : phase_q;
    phase_d = en ? (ph_use + 2'd1) : phase_q;
  end

  // Negation in W+1 bits; only -2^(W-1) overflows the W-bit range
  always_comb begin
    neg_src  = p1_q[0] ? {i1_q[W-1], i1_q} : {q1_q[W-1], q1_q};
    neg_full = -neg_src;
    clip     = (neg_full[W] != neg_full[W-1]);
    neg_val  = clip ? C_MAX_POS : neg_full[W-1:0];
  end

  always_comb begin
    od_d  = od_q;
    sat_d = 1'b0;
    if (v1_q) begin
      case (p1_q)
        2'd0:    od_d = q1_q;
        2'd1:    od_d = i1_q;
        default: od_d = neg_val;
      endcase
      sat_d = p1_q[1] & clip;
    end
    cnt_d = (sat_d && (cnt_q != C_CNT_MAX)) ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 2'd0;
      v1_q    <= 1'b0;
      i1_q    <= '0;
      q1_q    <= '0;
      p1_q    <= 2'd0;
      od_q    <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      v1_q    <= en;
      if (en) begin
        i1_q <= idi;
        q1_q <= idq;
        p1_q <= ph_use;
      end
      od_q    <= od_d;
      vld_q   <= v1_q;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign od       = od_q;
  assign od_valid = vld_q;
  assign sat_flag = sat_q;
  assign sat_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_fs4_upconv.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_fs4_upconv
// Purpose  : randomized + directed bench against a sample-level fs/4 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_fs4_upconv;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst, en, sync;
  logic signed [W-1:0] idi, idq;
  logic signed [W-1:0] od, od2;
  logic                od_valid, sat_flag, ov2, sf2;
  logic [15:0]         sat_cnt;
  logic [1:0]          sat_cnt2;

  always #5 clk = ~clk;

  iq_fs4_upconv #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .idi(idi), .idq(idq),
    .od(od), .od_valid(od_valid), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  iq_fs4_upconv #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .idi(idi), .idq(idq),
    .od(od2), .od_valid(ov2), .sat_flag(sf2), .sat_cnt(sat_cnt2)
  );

  int n_total = 0;
  int n_bad   = 0;

  // model: phase of next accepted sample, one pending sample, current outputs
  int m_ph;
  bit p_v, p_sat;
  int p_od;
  bit e_v, e_sat;
  int e_od, e_cnt, e_cnt2;
  int got[$];
  int xq[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sneg(input int x);
    return (-x > 2**(W-1) - 1) ? 2**(W-1) - 1 : -x;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit s, input int i, input int q);
    rst = r; en = e; sync = s; idi = W'(i); idq = W'(q);
    @(posedge clk);
    if (r) begin
      m_ph = 0; p_v = 0; p_sat = 0; p_od = 0;
      e_v = 0; e_od = 0; e_sat = 0; e_cnt = 0; e_cnt2 = 0;
    end else begin
      e_v   = p_v;
      e_sat = 0;
      if (p_v) begin
        e_od  = p_od;
        e_sat = p_sat;
        if (p_sat) begin
          if (e_cnt < 65535) e_cnt++;
          if (e_cnt2 < 3) e_cnt2++;
        end
      end
      p_v = e;
      if (e) begin
        int ph;
        ph = s ? 0 : m_ph;
        case (ph)
          0:       p_od = q;
          1:       p_od = i;
          2:       p_od = sneg(q);
          default: p_od = sneg(i);
        endcase
        p_sat = (ph >= 2) && (((ph == 2) ? q : i) == -(2**(W-1)));
        m_ph  = (ph + 1) % 4;
      end
    end
    #1;
    check_val("od_valid", od_valid, e_v);
    check_val("od", od, e_od);
    check_val("sat_flag", sat_flag, e_sat);
    check_val("sat_cnt", sat_cnt, e_cnt);
    check_val("sat_cnt_w2", sat_cnt2, e_cnt2);
    check_val("od_w2", od2, e_od);
    if (od_valid) got.push_back(od);
  endtask

  task automatic check_got(input string tag, input int exp[$]);
    check_val({tag, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      check_val(tag, got[k], exp[k]);
  endtask

  initial begin
    int ex[$];
    int x, ii, qq;
    bit e;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // phase sequence
    got.delete();
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 100, 200);
    cyc(0, 0, 0, 0, 0);
    ex = '{200, 100, -200, -100, 200, 100, -200, -100};
    check_got("phase_seq", ex);

    // gapped input
    cyc(1, 0, 0, 0, 0);
    got.delete();
    cyc(0, 1, 0, 5, 7); cyc(0, 0, 0, 5, 7); cyc(0, 1, 0, 5, 7); cyc(0, 1, 0, 5, 7);
    cyc(0, 0, 0, 5, 7); cyc(0, 0, 0, 5, 7); cyc(0, 1, 0, 5, 7);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    ex = '{7, 5, -7, -5};
    check_got("gapped", ex);

    // sync realign, sync without en ignored
    cyc(1, 0, 0, 0, 0);
    got.delete();
    cyc(0, 1, 0, 11, 22); cyc(0, 1, 0, 11, 22);
    cyc(0, 0, 1, 11, 22);
    cyc(0, 1, 1, 11, 22); cyc(0, 1, 0, 11, 22); cyc(0, 1, 0, 11, 22);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    ex = '{22, 11, 22, 11, -22};
    check_got("sync", ex);

    // saturation
    cyc(1, 0, 0, 0, 0);
    got.delete();
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, -2048, -2048);
    cyc(0, 0, 0, 0, 0);
    ex = '{-2048, -2048, 2047, 2047, -2048, -2048, 2047, 2047};
    check_got("sat_seq", ex);
    check_val("sat_cnt_end", sat_cnt, 4);
    check_val("sat_cnt_w2_stick", sat_cnt2, 3);
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, -2048, -2048);
    cyc(0, 0, 0, 0, 0);
    check_val("sat_cnt_more", sat_cnt, 8);
    check_val("sat_cnt_w2_hold", sat_cnt2, 3);

    // reset mid-stream
    cyc(0, 1, 0, 1, 2);
    cyc(1, 1, 0, 3, 4);
    check_val("rst_od", od, 0);
    check_val("rst_valid", od_valid, 0);
    check_val("rst_cnt", sat_cnt, 0);
    got.delete();
    cyc(0, 1, 0, 33, 44); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    ex = '{44};
    check_got("post_rst", ex);

    // randomized traffic including full-scale negative values
    for (int k = 0; k < 400; k++) begin
      ii = ($urandom_range(7, 0) == 0) ? -2048 : int'($urandom_range(4095, 0)) - 2048;
      qq = ($urandom_range(7, 0) == 0) ? -2048 : int'($urandom_range(4095, 0)) - 2048;
      cyc(($urandom_range(63, 0) == 0), ($urandom_range(3, 0) != 0),
          ($urandom_range(9, 0) == 0), ii, qq);
    end

    // loopback through an ideal receive-side fs/4 split
    cyc(1, 0, 0, 0, 0);
    got.delete();
    xq.delete();
    for (int k = 0; k < 1000; k++) begin
      e = ($urandom_range(9, 0) != 0);
      x = int'($urandom_range(4094, 0)) - 2047;
      ii = int'($urandom_range(4094, 0)) - 2047;
      qq = int'($urandom_range(4094, 0)) - 2047;
      case (m_ph)
        0:       qq = x;
        1:       ii = x;
        2:       qq = -x;
        default: ii = -x;
      endcase
      if (e) xq.push_back(x);
      cyc(0, e, 0, ii, qq);
    end
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    check_got("loopback", xq);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
